inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives an SRAM-like instruction bus with one
// outstanding transaction and a single-entry output buffer toward decode.
// Optional feature: define IFETCH_ADEL_EN to turn a misaligned fetch address
// into an address-error slot instead of a bus request.
module inst_fetch_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    input  logic        stall_d,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        inst_valid,
    output logic        inst_adel,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        StReq     = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q;
    logic        misaligned;
    logic        buf_blocked;
    logic        data_take;
    logic        adel_load;

    // Fetch is read-only, always word-sized.
    assign inst_wr   = 1'b0;
    assign inst_size = 2'b10;
    assign inst_addr = pc;

`ifdef IFETCH_ADEL_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Buffer cannot take a new entry while decode is holding the current one.
    assign buf_blocked = inst_valid && stall_d;

    // Next-state logic and bus request generation.
    always_comb begin
        state_d  = state_q;
        inst_req = 1'b0;
        pc_en    = 1'b0;
        unique case (state_q)
            StReq: begin
                inst_req = !rst && !flush && !buf_blocked && !misaligned;
                if (inst_req && inst_addr_ok) begin
                    pc_en   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    // Response arriving with the flush is simply dropped.
                    state_d = inst_data_ok ? StReq : StDiscard;
                end else if (inst_data_ok) begin
                    state_d = StReq;
                end
            end
            StDiscard: begin
                if (inst_data_ok) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    assign data_take = (state_q == StWait) && inst_data_ok && !flush;
    assign adel_load = (state_q == StReq) && misaligned && !flush && !buf_blocked;

    // State register; reset abandons any outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // Address of the accepted request, tagged onto the returning word.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q <= 32'h0;
        end else if (pc_en) begin
            req_pc_q <= pc;
        end
    end

    // Output buffer: flush wins, then refill, then consume by decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            inst_pc    <= 32'h0;
        end else if (flush) begin
            inst_valid <= 1'b0;
        end else if (data_take) begin
            inst_valid <= 1'b1;
            inst_out   <= inst_rdata;
            inst_pc    <= req_pc_q;
        end else if (adel_load) begin
            inst_valid <= 1'b1;
            inst_out   <= NOP_INST;
            inst_pc    <= pc;
        end else if (inst_valid && !stall_d) begin
            inst_valid <= 1'b0;
        end
    end

`ifdef IFETCH_ADEL_EN
    logic adel_q;

    // Address-error flag follows the buffer entry it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else if (flush) begin
            adel_q <= 1'b0;
        end else if (data_take) begin
            adel_q <= 1'b0;
        end else if (adel_load) begin
            adel_q <= 1'b1;
        end else if (inst_valid && !stall_d) begin
            adel_q <= 1'b0;
        end
    end

    assign inst_adel = adel_q;
`else
    assign inst_adel = 1'b0;
`endif

endmodule
